hex_msg_sequencer: RTL
======================

// Module: hex_msg_sequencer
// PURPOSE
//  Produces the six 5-bit character codes that feed the seg7 decoders on HEX5..HEX0.
//  During play it shows the 8-bit score as two hex digits.
//  At game end it shows a static WIN or LOSE banner, then scrolls "GAMEOVER" right-to-left
//  until game_over deasserts.
//  Character codes: 0-F hex digits, 10=G, 13=L, 14=M, 16=O, 19=R, 1A=S, 1C=U, 1D=V, 1E=blank.
// PARAMETERS
//  SCROLL_TICKS  12_500_000  clk cycles per scroll/hold step (4 steps/s at 50 MHz); must be >= 2
//  HOLD_STEPS    8           steps the WIN/LOSE banner is held before GAMEOVER scrolling; must be >= 1
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset        in   1  asynchronous, active-high reset
//  game_over    in   1  level; 1 = game ended (held by game FSM until restart)
//  win          in   1  level; outcome, sampled only on the cycle PLAY exits
//  score        in   8  current score, unsigned
//  hex5..hex0   out  5  character codes each; hex5 = leftmost display; registered
//  scroll_wrap  out  1  one-cycle pulse when the scroll position wraps 13->0
//  mode         out  2  current state: 0=PLAY, 1=WIN, 2=LOSE, 3=OVER
// BEHAVIOUR
//  Reset values:
//   - state PLAY; tick counter, step counter and pos = 0
//   - hex5..hex2 = 5'h1E; hex1 = hex0 = 5'h00
//   - scroll_wrap = 0; mode = 0
//  Tick:
//   - counter runs 0..SCROLL_TICKS-1; tick pulses when counter == SCROLL_TICKS-1
//   - counter clears to 0 on every state change
//  FSM (next-state evaluated every cycle):
//   - PLAY: game_over=1 -> WIN if win=1 else LOSE; step counter cleared.
//   - WIN/LOSE: game_over=0 -> PLAY (highest priority). Else on tick: step++;
//     a tick while step==HOLD_STEPS-1 -> OVER with pos=0.
//     So the banner shows for exactly HOLD_STEPS*SCROLL_TICKS cycles.
//   - OVER: game_over=0 -> PLAY (priority over tick). Else on tick: pos = (pos==13) ? 0 : pos+1.
//     scroll_wrap=1 on the cycle after the tick that wraps pos.
//   - The win input is ignored outside PLAY; toggling win in WIN/LOSE has no effect.
//  Display content (registered; each output reflects the state/pos/score of the previous cycle):
//   - PLAY: hex5..hex2 = 1E; hex1 = {0,score[7:4]}; hex0 = {0,score[3:0]}.
//   - WIN: hex5..hex0 = 1E,1E,1C,1C,01,15 ("  UU1N"; UU approximates W).
//   - LOSE: hex5..hex0 = 1E,1E,13,16,1A,0E ("  LOSE").
//   - OVER: stream S[0..13] = 1E x6, then 10,0A,14,0E,16,1D,0E,19 ("GAMEOVER").
//     hex5 = S[pos], hex4 = S[(pos+1)%14], ... hex0 = S[(pos+5)%14], wrap modulo 14.
//     pos=0 gives all blank; pos=6 gives "GAMEOV"; pos=8 gives "MEOVER".
//  Arithmetic: pos is 4 bits, never exceeds 13; step counter is sized $clog2(HOLD_STEPS+1).
//  Reset mid-operation: asynchronous return to all reset values in the same edge; no partial scroll resumes.
// TESTING
//  (bench uses SCROLL_TICKS=4, HOLD_STEPS=2)
//  1. Reset, score=8'hA7, game_over=0 -> one clk later hex1=0A, hex0=07, hex5..2=1E, mode=0.
//  2. game_over=1, win=0 -> mode=2 and "  LOSE" from next cycle, held exactly 8 cycles,
//     then mode=3 with all-blank displays.
//  3. In OVER, count ticks -> after 6 ticks hex5..0 = 10,0A,14,0E,16,1D;
//     after 14 ticks scroll_wrap pulses once (1 cycle) and displays are blank.
//  4. game_over=1, win=1, then toggle win during the hold -> banner stays "  UU1N", mode stays 1.
//  5. game_over dropped on the same cycle as a hold-expiry tick -> mode=0, score shown, no OVER entry.
//  6. Assert reset mid-scroll at pos=9 -> outputs return to reset values immediately (async);
//     after release, PLAY resumes.

Source files
------------

// File: rtl/hex_msg_sequencer.sv
// hex_msg_sequencer: drives the six seg7 character codes (HEX5..HEX0).
// Shows the score while playing, a WIN/LOSE banner at game end, and then
// scrolls "GAMEOVER" right-to-left until game_over drops.
module hex_msg_sequencer #(
    parameter int unsigned SCROLL_TICKS = 12_500_000, // cycles per scroll/hold step, >= 2
    parameter int unsigned HOLD_STEPS   = 8           // banner steps before scrolling, >= 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_over,
    input  logic       win,
    input  logic [7:0] score,
    output logic [4:0] hex5,
    output logic [4:0] hex4,
    output logic [4:0] hex3,
    output logic [4:0] hex2,
    output logic [4:0] hex1,
    output logic [4:0] hex0,
    output logic       scroll_wrap,
    output logic [1:0] mode
);

    localparam int unsigned TW = $clog2(SCROLL_TICKS);
    localparam int unsigned SW = $clog2(HOLD_STEPS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCROLL_TICKS - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(HOLD_STEPS - 1);

    localparam logic [4:0] BL = 5'h1E;
    localparam logic [5:0][4:0] HEX_RESET = {BL, BL, BL, BL, 5'h00, 5'h00};
    localparam logic [5:0][4:0] HEX_WIN   = {BL, BL, 5'h1C, 5'h1C, 5'h01, 5'h15};
    localparam logic [5:0][4:0] HEX_LOSE  = {BL, BL, 5'h13, 5'h16, 5'h1A, 5'h0E};

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_WIN  = 2'd1,
        S_LOSE = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   step_q, step_d;
    logic [3:0]      pos_q, pos_d;
    logic            wrap_q, wrap_d;
    logic [5:0][4:0] hex_q, hex_d;
    logic            tick;

    // Scroll stream: six blanks followed by "GAMEOVER", 14 entries total.
    function automatic logic [4:0] stream_chr(input logic [3:0] idx);
        logic [4:0] c;
        case (idx)
            4'd6:    c = 5'h10; // G
            4'd7:    c = 5'h0A; // A
            4'd8:    c = 5'h14; // M
            4'd9:    c = 5'h0E; // E
            4'd10:   c = 5'h16; // O
            4'd11:   c = 5'h1D; // V
            4'd12:   c = 5'h0E; // E
            4'd13:   c = 5'h19; // R
            default: c = BL;
        endcase
        return c;
    endfunction

    // Index into the stream for display slot k (0 = leftmost), modulo 14.
    function automatic logic [3:0] stream_idx(input logic [3:0] pos, input int k);
        logic [4:0] s;
        s = {1'b0, pos} + 5'(k);
        if (s >= 5'd14) s = s - 5'd14;
        return s[3:0];
    endfunction

    assign tick = (cnt_q == TICK_LAST);

    // Next-state: game FSM, hold-step counter, scroll position, wrap pulse, tick counter.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        case (state_q)
            S_PLAY: begin
                step_d = '0;
                if (game_over) state_d = win ? S_WIN : S_LOSE;
            end
            S_WIN, S_LOSE: begin
                // Dropping game_over beats a coincident hold-expiry tick.
                if (!game_over) begin
                    state_d = S_PLAY;
                end else if (tick) begin
                    if (step_q == STEP_LAST) begin
                        state_d = S_OVER;
                        pos_d   = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (!game_over) begin
                    state_d = S_PLAY;
                end else if (tick) begin
                    if (pos_q == 4'd13) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
            end
            default: state_d = S_PLAY;
        endcase
        // Step timing restarts cleanly on every state change.
        cnt_d = ((state_d != state_q) || tick) ? '0 : cnt_q + 1'b1;
    end

    // Display content from the current state; registered below, so one cycle behind.
    always_comb begin
        hex_d = {BL, BL, BL, BL, BL, BL};
        case (state_q)
            S_PLAY: begin
                hex_d[1] = {1'b0, score[7:4]};
                hex_d[0] = {1'b0, score[3:0]};
            end
            S_WIN:  hex_d = HEX_WIN;
            S_LOSE: hex_d = HEX_LOSE;
            S_OVER: begin
                for (int k = 0; k < 6; k++) begin
                    hex_d[5-k] = stream_chr(stream_idx(pos_q, k));
                end
            end
            default: hex_d = HEX_RESET;
        endcase
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_PLAY;
            cnt_q   <= '0;
            step_q  <= '0;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            hex_q   <= HEX_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            hex_q   <= hex_d;
        end
    end

    assign hex5        = hex_q[5];
    assign hex4        = hex_q[4];
    assign hex3        = hex_q[3];
    assign hex2        = hex_q[2];
    assign hex1        = hex_q[1];
    assign hex0        = hex_q[0];
    assign scroll_wrap = wrap_q;
    assign mode        = state_q;

endmodule
